fp2_ptwise_sq_mux: RTL and testbench

// - Pointwise F_{p^2} squaring of NUM_LANES independent elements (a + b*i, i^2 = -1).
// - Time-multiplexes NUM_UNITS fp2_sqr cores instead of one core per lane.
// - valid/ready handshake on both sides; the fixed-latency 4-lane squarer becomes a

---
 rtl/fp2_ptwise_sq_mux_pkg.sv | 44 ++++
 rtl/fp2_ptwise_sq_mux_if.sv | 26 ++
 rtl/fp2_ptwise_sq_mux_sqr.sv | 33 +++
 rtl/fp2_ptwise_sq_mux.sv | 162 ++++++++++++++++
 tb/tb_fp2_ptwise_sq_mux.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp2_ptwise_sq_mux_pkg.sv
// Shared constants for the pointwise F_{p^2} squarer: field modulus, core latency,
// FSM encoding and the modular helpers used by the squaring core.
package fp2_ptwise_sq_mux_pkg;

    localparam int unsigned FP_W        = 255;
    localparam logic [FP_W-1:0] FP_Q    =
        255'd2261564242916331941866620800950935700259179388000792266395655937654553313279;
    localparam int unsigned SQR_LATENCY = 18;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [FP_W-1:0] mod_add(input logic [FP_W-1:0] a,
                                                input logic [FP_W-1:0] b);
        logic [FP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FP_Q}) begin
            s = s - {1'b0, FP_Q};
        end
        return s[FP_W-1:0];
    endfunction

    // A borrow wraps modulo 2^(FP_W+1); adding q brings it back into [0, q).
    function automatic logic [FP_W-1:0] mod_sub(input logic [FP_W-1:0] a,
                                                input logic [FP_W-1:0] b);
        logic [FP_W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            s = s + {1'b0, FP_Q};
        end
        return s[FP_W-1:0];
    endfunction

    function automatic logic [FP_W-1:0] mod_mul(input logic [FP_W-1:0] a,
                                                input logic [FP_W-1:0] b);
        logic [2*FP_W-1:0] p;
        p = {{FP_W{1'b0}}, a} * {{FP_W{1'b0}}, b};
        p = p % {{FP_W{1'b0}}, FP_Q};
        return p[FP_W-1:0];
    endfunction

endpackage

// File: rtl/fp2_ptwise_sq_mux_if.sv
// Batch handshake bundle: input batch (valid/ready + lanes) and result batch (valid/ready + lanes).
interface fp2_ptwise_sq_mux_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned W         = 255
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_LANES*W-1:0] in_re;
    logic [NUM_LANES*W-1:0] in_im;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_LANES*W-1:0] out_re;
    logic [NUM_LANES*W-1:0] out_im;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );

endinterface

// File: rtl/fp2_ptwise_sq_mux_sqr.sv
// Single F_{p^2} squaring core: (a + b*i)^2 = (a+b)(a-b) + 2ab*i, fixed-latency pipeline.
module fp2_ptwise_sq_mux_sqr
    import fp2_ptwise_sq_mux_pkg::*;
(
    input  logic            clk,
    input  logic [FP_W-1:0] i_a1,
    input  logic [FP_W-1:0] i_b1,
    output logic [FP_W-1:0] o_d1,
    output logic [FP_W-1:0] o_d2
);

    logic [FP_W-1:0] w_d1;
    logic [FP_W-1:0] w_d2;
    logic [FP_W-1:0] r_d1 [SQR_LATENCY];
    logic [FP_W-1:0] r_d2 [SQR_LATENCY];

    assign w_d1 = mod_mul(mod_add(i_a1, i_b1), mod_sub(i_a1, i_b1));
    assign w_d2 = mod_mul(mod_add(i_a1, i_a1), i_b1);

    // Pure delay line; no reset, the caller decides which outputs are meaningful.
    always_ff @(posedge clk) begin
        r_d1[0] <= w_d1;
        r_d2[0] <= w_d2;
        for (int i = 1; i < SQR_LATENCY; i++) begin
            r_d1[i] <= r_d1[i-1];
            r_d2[i] <= r_d2[i-1];
        end
    end

    assign o_d1 = r_d1[SQR_LATENCY-1];
    assign o_d2 = r_d2[SQR_LATENCY-1];

endmodule

// File: rtl/fp2_ptwise_sq_mux.sv
// Pointwise F_{p^2} squaring of NUM_LANES elements, time-multiplexed over NUM_UNITS
// fixed-latency squaring cores with valid/ready handshakes on both sides.
module fp2_ptwise_sq_mux
    import fp2_ptwise_sq_mux_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned NUM_UNITS = 2,
    parameter int unsigned W         = FP_W
) (
    input logic                clk,
    input logic                rst,
    fp2_ptwise_sq_mux_if.slave bus
);

    localparam int unsigned ROUNDS = NUM_LANES / NUM_UNITS;
    localparam int unsigned GW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    logic [1:0]             r_state;
    logic [GW-1:0]          r_group;
    logic [SQR_LATENCY-1:0] r_tok_vld;
    logic [GW-1:0]          r_tok_grp [SQR_LATENCY];

    logic [W-1:0] r_op_re  [NUM_LANES];
    logic [W-1:0] r_op_im  [NUM_LANES];
    logic [W-1:0] r_res_re [NUM_LANES];
    logic [W-1:0] r_res_im [NUM_LANES];

    logic [W-1:0] w_in_re   [NUM_LANES];
    logic [W-1:0] w_in_im   [NUM_LANES];
    logic [W-1:0] w_unit_re [NUM_UNITS];
    logic [W-1:0] w_unit_im [NUM_UNITS];
    logic [W-1:0] w_core_re [NUM_UNITS];
    logic [W-1:0] w_core_im [NUM_UNITS];

    logic          w_issue;
    logic          w_accept;
    logic          w_last_grp;
    logic          w_tok_out_vld;
    logic [GW-1:0] w_tok_out_grp;
    logic          w_last_tok;

    assign w_issue       = (r_state == ST_ISSUE);
    assign w_accept      = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last_grp    = (r_group == GW'(ROUNDS - 1));
    assign w_tok_out_vld = r_tok_vld[SQR_LATENCY-1];
    assign w_tok_out_grp = r_tok_grp[SQR_LATENCY-1];
    assign w_last_tok    = w_tok_out_vld && (w_tok_out_grp == GW'(ROUNDS - 1));

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_group <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_group <= '0;
                    if (bus.in_valid) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_last_grp) begin
                        r_group <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_group <= r_group + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_last_tok) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tokens track which group each core result belongs to; clearing them on reset
    // discards anything still in flight inside the cores.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tok_vld <= '0;
            for (int i = 0; i < SQR_LATENCY; i++) begin
                r_tok_grp[i] <= '0;
            end
        end else begin
            r_tok_vld    <= {r_tok_vld[SQR_LATENCY-2:0], w_issue};
            r_tok_grp[0] <= r_group;
            for (int i = 1; i < SQR_LATENCY; i++) begin
                r_tok_grp[i] <= r_tok_grp[i-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign w_in_re[k]             = bus.in_re[k*W +: W];
        assign w_in_im[k]             = bus.in_im[k*W +: W];
        assign bus.out_re[k*W +: W]   = r_res_re[k];
        assign bus.out_im[k*W +: W]   = r_res_im[k];
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_op_re[k] <= w_in_re[k];
                r_op_im[k] <= w_in_im[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_res_re[k] <= '0;
                r_res_im[k] <= '0;
            end
        end else if (w_tok_out_vld) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (GW'(k / NUM_UNITS) == w_tok_out_grp) begin
                    r_res_re[k] <= w_core_re[k % NUM_UNITS];
                    r_res_im[k] <= w_core_im[k % NUM_UNITS];
                end
            end
        end
    end

    // Unit u takes lane g*NUM_UNITS+u during issue; idle cores see zeros.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_unit_re[u] = '0;
            w_unit_im[u] = '0;
            if (w_issue) begin
                for (int g = 0; g < ROUNDS; g++) begin
                    if (r_group == GW'(g)) begin
                        w_unit_re[u] = r_op_re[g*NUM_UNITS + u];
                        w_unit_im[u] = r_op_im[g*NUM_UNITS + u];
                    end
                end
            end
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        fp2_ptwise_sq_mux_sqr u_sqr (
            .clk  (clk),
            .i_a1 (w_unit_re[u]),
            .i_b1 (w_unit_im[u]),
            .o_d1 (w_core_re[u]),
            .o_d2 (w_core_im[u])
        );
    end

endmodule

// File: tb/tb_fp2_ptwise_sq_mux.sv
// Self-checking bench: directed latency/hold/ignore/reset cases on 1, 2 and 4 unit
// builds, then random batches against a plain modular-arithmetic reference.
module tb_fp2_ptwise_sq_mux;
    import fp2_ptwise_sq_mux_pkg::*;

    localparam int unsigned NL     = 4;
    localparam int unsigned W      = FP_W;
    localparam int unsigned CW     = NL * W;
    localparam int unsigned NBATCH = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_re;
    logic [CW-1:0] in_im;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp2_ptwise_sq_mux_if #(.NUM_LANES(NL), .W(W)) bus2 ();
    fp2_ptwise_sq_mux_if #(.NUM_LANES(NL), .W(W)) bus4 ();
    fp2_ptwise_sq_mux_if #(.NUM_LANES(NL), .W(W)) bus1 ();

    assign bus2.in_valid  = in_valid;
    assign bus2.in_re     = in_re;
    assign bus2.in_im     = in_im;
    assign bus2.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.in_re     = in_re;
    assign bus4.in_im     = in_im;
    assign bus4.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_re     = in_re;
    assign bus1.in_im     = in_im;
    assign bus1.out_ready = out_ready;

    fp2_ptwise_sq_mux #(.NUM_LANES(NL), .NUM_UNITS(2), .W(W)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    fp2_ptwise_sq_mux #(.NUM_LANES(NL), .NUM_UNITS(4), .W(W)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );
    fp2_ptwise_sq_mux #(.NUM_LANES(NL), .NUM_UNITS(1), .W(W)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [CW-1:0] got_re,
                               input logic [CW-1:0] got_im, input logic [CW-1:0] want_re,
                               input logic [CW-1:0] want_im);
        for (int k = 0; k < NL; k++) begin
            check_eq($sformatf("%s_re%0d", tag, k), got_re[k*W +: W], want_re[k*W +: W]);
            check_eq($sformatf("%s_im%0d", tag, k), got_im[k*W +: W], want_im[k*W +: W]);
        end
    endtask

    function automatic logic [CW-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                            input logic [W-1:0] l2, input logic [W-1:0] l3);
        logic [CW-1:0] v;
        v[0*W +: W] = l0;
        v[1*W +: W] = l1;
        v[2*W +: W] = l2;
        v[3*W +: W] = l3;
        return v;
    endfunction

    // Reference: a^2 - b^2 and 2ab reduced with wide plain arithmetic.
    function automatic logic [W-1:0] ref_re(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [511:0] x, y, q, aa, bb;
        x  = 512'(a);
        y  = 512'(b);
        q  = 512'(FP_Q);
        aa = (x * x) % q;
        bb = (y * y) % q;
        return W'((aa + q - bb) % q);
    endfunction

    function automatic logic [W-1:0] ref_im(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [511:0] x, y, q;
        x = 512'(a);
        y = 512'(b);
        q = 512'(FP_Q);
        return W'((2 * x * y) % q);
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [255:0] r;
        int unsigned  sel;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return FP_Q - 1;
        if (sel == 2) return W'($urandom_range(0, 3));
        return W'(r % 256'(FP_Q));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [CW-1:0] va_re, va_im, ea_re, ea_im, vb_re, vb_im, eb_re, eb_im;
    logic [CW-1:0] sb_re [$];
    logic [CW-1:0] sb_im [$];

    initial begin
        int f2, f4, f1, seen, acc, dlv, cyc;
        logic          hold_pend;
        logic [CW-1:0] hold_re, hold_im, x_re, x_im, e_re, e_im;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
        va_re = pack4(3, 0, 1, 0);
        va_im = pack4(4, 1, 1, 0);
        ea_re = pack4(FP_Q - 7, FP_Q - 1, 0, 0);
        ea_im = pack4(24, 0, 2, 0);
        vb_re = pack4(2, 2, 2, 2);
        vb_im = '0;
        eb_re = pack4(4, 4, 4, 4);
        eb_im = '0;

        // Reset state, then first-result latency of all three builds.
        do_reset();
        check_eq("rst_in_ready", W'(bus2.in_ready), 1);
        check_eq("rst_out_valid", W'(bus2.out_valid), 0);
        check_lanes("rst_out", bus2.out_re, bus2.out_im, '0, '0);

        in_re = va_re; in_im = va_im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        f2 = 0; f4 = 0; f1 = 0;
        // Observation after edge k; a value first seen here is sampled high at edge k+1.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("issue_in_ready", W'(bus2.in_ready), 0);
            if (k == 10) check_eq("wait_in_ready", W'(bus2.in_ready), 0);
            if (f2 == 0 && bus2.out_valid) f2 = k + 1;
            if (f4 == 0 && bus4.out_valid) f4 = k + 1;
            if (f1 == 0 && bus1.out_valid) f1 = k + 1;
            if (f2 != 0 && f4 != 0 && f1 != 0) break;
        end
        check_eq("lat_u2", W'(f2), W'(NL / 2 + SQR_LATENCY + 1));
        check_eq("lat_u4", W'(f4), W'(NL / 4 + SQR_LATENCY + 1));
        check_eq("lat_u1", W'(f1), W'(NL / 1 + SQR_LATENCY + 1));
        check_lanes("res_u2", bus2.out_re, bus2.out_im, ea_re, ea_im);
        check_lanes("res_u4", bus4.out_re, bus4.out_im, ea_re, ea_im);
        check_lanes("res_u1", bus1.out_re, bus1.out_im, ea_re, ea_im);

        // Back-pressure: outputs held, no new input accepted.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_valid", W'(bus2.out_valid), 1);
            check_eq("hold_in_ready", W'(bus2.in_ready), 0);
            check_lanes("hold", bus2.out_re, bus2.out_im, ea_re, ea_im);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("rel_out_valid", W'(bus2.out_valid), 0);
        check_eq("rel_in_ready", W'(bus2.in_ready), 1);

        // Extra in_valid pulses during ISSUE and WAIT must be ignored.
        do_reset();
        in_re = va_re; in_im = va_im; in_valid = 1'b1;
        @(negedge clk);
        in_re = vb_re; in_im = vb_im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clk);
            if (bus2.out_valid) seen = 1;
        end
        check_eq("ign_valid", W'(seen), 1);
        check_lanes("ign_res", bus2.out_re, bus2.out_im, ea_re, ea_im);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus2.out_valid) seen++;
        end
        out_ready = 1'b0;
        check_eq("ign_no_extra", W'(seen), 0);

        // Reset at cycle 8 of a batch; the following batch is unaffected.
        do_reset();
        in_re = va_re; in_im = va_im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_in_ready", W'(bus2.in_ready), 1);
        check_eq("mid_rst_out_valid", W'(bus2.out_valid), 0);
        in_re = vb_re; in_im = vb_im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        f2 = 0;
        for (int k = 1; k <= 40 && f2 == 0; k++) begin
            @(negedge clk);
            if (bus2.out_valid) f2 = k + 1;
        end
        check_eq("mid_rst_lat", W'(f2), W'(NL / 2 + SQR_LATENCY + 1));
        check_lanes("mid_rst_res", bus2.out_re, bus2.out_im, eb_re, eb_im);

        // Random batches with random back-pressure against the reference scoreboard.
        do_reset();
        acc = 0; dlv = 0; cyc = 0; hold_pend = 1'b0; hold_re = '0; hold_im = '0;
        while (dlv < NBATCH && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (hold_pend) begin
                check_eq("rnd_hold_valid", W'(bus2.out_valid), 1);
                check_eq("rnd_hold_data",
                         W'(bus2.out_re == hold_re && bus2.out_im == hold_im), 1);
            end
            in_valid = (acc < NBATCH) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NL; k++) begin
                in_re[k*W +: W] = rand_elem();
                in_im[k*W +: W] = rand_elem();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && bus2.in_ready) begin
                for (int k = 0; k < NL; k++) begin
                    e_re[k*W +: W] = ref_re(in_re[k*W +: W], in_im[k*W +: W]);
                    e_im[k*W +: W] = ref_im(in_re[k*W +: W], in_im[k*W +: W]);
                end
                sb_re.push_back(e_re);
                sb_im.push_back(e_im);
                acc++;
            end
            if (bus2.out_valid && out_ready) begin
                check_eq("rnd_sb_occupied", W'(sb_re.size() > 0), 1);
                if (sb_re.size() > 0) begin
                    x_re = sb_re.pop_front();
                    x_im = sb_im.pop_front();
                    check_lanes($sformatf("rnd_b%0d", dlv), bus2.out_re, bus2.out_im, x_re, x_im);
                end
                dlv++;
            end
            hold_pend = bus2.out_valid && !out_ready;
            hold_re   = bus2.out_re;
            hold_im   = bus2.out_im;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("rnd_accepted", W'(acc), W'(NBATCH));
        check_eq("rnd_delivered", W'(dlv), W'(NBATCH));
        check_eq("rnd_leftover", W'(sb_re.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
